pwr_btn_arbiter: RTL and testbench
==================================

Name: pwr_btn_arbiter

Overview:
Shares the single PCH power-button line between the front-panel button and BMC power-button requests. The front-panel input arrives already glitch-filtered. The block sequences clean, timed assertions of o_FM_PCH_PWRBTN_N: pass-through for front-panel presses with a minimum width, and fixed-length short or long override presses for the BMC. A mandatory release gap follows every press. BMC requests that cannot be served are reported back, never queued.

Parameters:
CNT_W, 28, width of the shared duration counter
SHORT_CYC, 5_000_000, BMC short-press low time in CLK cycles (200 ms at 25 MHz)
LONG_CYC, 150_000_000, BMC long/override-press low time in CLK cycles (6 s)
GAP_CYC, 2_500_000, forced high (released) time after any press (100 ms)
FP_MIN_CYC, 25_000, minimum low time for a front-panel press (1 ms)
- Rule: every *_CYC value must be >= 1 and < 2^CNT_W.

Ports:
CLK  in  1  system clock; the only clock
RESET  in  1  synchronous, active-high reset
i_FP_PWR_BTN_N  in  1  filtered front-panel button, low = pressed
i_FP_DISABLE  in  1  1 = ignore new front-panel presses (BMC lockout)
i_BMC_PWR_BTN  in  1  one-cycle request strobe from BMC register
i_BMC_LONG  in  1  sampled with the strobe: 1 = LONG_CYC, 0 = SHORT_CYC
o_FM_PCH_PWRBTN_N  out  1  registered power button to PCH, low = pressed
o_BMC_BUSY  out  1  high whenever state != IDLE
o_BMC_DONE  out  1  one-cycle pulse when a BMC press completes its low time
o_BMC_REJECT  out  1  one-cycle pulse when a BMC strobe is refused
o_OWNER  out  2  00 none, 01 front panel, 10 BMC (only during press states)

Behaviour:
- Reset values (applied at the first CLK edge with RESET=1): state IDLE, o_FM_PCH_PWRBTN_N=1, o_BMC_BUSY=0, o_BMC_DONE=0, o_BMC_REJECT=0, o_OWNER=00, counter=0, fp_prev=1.
- Reset mid-press: the output goes high at that edge. No DONE pulse is issued.
- fp_prev is a register that follows i_FP_PWR_BTN_N every cycle.
- Front-panel falling edge = fp_prev==1 && i_FP_PWR_BTN_N==0, evaluated combinationally in the current cycle.
- All outputs are registered. They are decoded from the next state, so the output changes at the same edge as the state.
- States: IDLE, FP_PRESS, BMC_PRESS, GAP. The counter clears to 0 on every state entry and increments each cycle while in a state.
- IDLE transitions:
  - Falling edge and !i_FP_DISABLE -> FP_PRESS.
  - Else if i_BMC_PWR_BTN -> BMC_PRESS; latch i_BMC_LONG.
  - Both in the same cycle: front panel wins, and the BMC strobe is rejected (REJECT pulse next edge).
- FP_PRESS:
  - Output 0, OWNER=01.
  - Exit to GAP when i_FP_PWR_BTN_N==1 and counter >= FP_MIN_CYC-1.
  - Counter saturates at its maximum value.
  - Release before the minimum: stay until counter == FP_MIN_CYC-1, giving exactly FP_MIN_CYC cycles low.
  - i_FP_DISABLE asserted mid-press does not truncate the press.
- BMC_PRESS:
  - Output 0, OWNER=10.
  - Exit to GAP when counter == DUR-1, where DUR = latched LONG ? LONG_CYC : SHORT_CYC. Output is low exactly DUR cycles.
  - o_BMC_DONE pulses on the exit edge.
  - Front-panel activity is ignored.
- GAP:
  - Output 1, OWNER=00.
  - Exit to IDLE when counter == GAP_CYC-1, giving exactly GAP_CYC cycles high.
- BMC strobe in any state other than IDLE: REJECT pulse at the next edge. State is unaffected.
- A front-panel button held across BMC_PRESS/GAP produces no falling edge in IDLE and is therefore ignored. The button must be released and pressed again.
- Latency: input sampled at edge k -> output changes at edge k (registered decision), i.e. visible one cycle after the input is presented.

Test Plan:
(Bench parameters: CNT_W=8, SHORT_CYC=4, LONG_CYC=10, GAP_CYC=3, FP_MIN_CYC=5.)
1. Reset, then one BMC strobe with LONG=0 -> output low 4 cycles, DONE pulse on release edge, high 3 cycles, BUSY high for 7 cycles total, OWNER=10 for 4 cycles.
2. BMC strobe with LONG=1, plus a second strobe 2 cycles later -> output low 10 cycles; one REJECT pulse 1 cycle after the second strobe; single DONE pulse.
3. Front-panel press held 20 cycles -> output low 20 cycles, OWNER=01; then 3 high gap cycles, then IDLE.
4. Front-panel 1-cycle press -> output low exactly 5 cycles, then 3 gap cycles. Assert i_FP_DISABLE, press again -> output stays 1, state IDLE.
5. Front-panel falling edge and BMC strobe in the same cycle -> FP_PRESS entered, REJECT pulse, no DONE. Front panel pressed during BMC_PRESS and held past GAP -> no second press until release and re-press.
6. RESET asserted in cycle 3 of a LONG BMC press -> output 1 at that edge, DONE never pulses, BUSY=0, OWNER=00. A following strobe is accepted normally.

Source files
------------

// File: rtl/pwr_btn_arbiter.sv
// Arbitrates the PCH power-button line between the front-panel button and BMC press requests.
// BMC requests are strobe-only: each strobe is answered by entering a press or by a REJECT pulse, never queued.
module pwr_btn_arbiter #(
  parameter int unsigned CNT_W      = 28,
  parameter int unsigned SHORT_CYC  = 5_000_000,
  parameter int unsigned LONG_CYC   = 150_000_000,
  parameter int unsigned GAP_CYC    = 2_500_000,
  parameter int unsigned FP_MIN_CYC = 25_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_FP_PWR_BTN_N,
  input  logic       i_FP_DISABLE,
  input  logic       i_BMC_PWR_BTN,
  input  logic       i_BMC_LONG,
  output logic       o_FM_PCH_PWRBTN_N,
  output logic       o_BMC_BUSY,
  output logic       o_BMC_DONE,
  output logic       o_BMC_REJECT,
  output logic [1:0] o_OWNER
);

  typedef enum logic [1:0] {IDLE, FP_PRESS, BMC_PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] FP_MIN_LAST = CNT_W'(FP_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fp_prev_q;
  logic             long_q, long_d;
  logic             pwrbtn_n_q, pwrbtn_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic [1:0]       owner_q, owner_d;
  logic             fp_fall;
  logic [CNT_W-1:0] dur_last;

  assign fp_fall  = fp_prev_q & ~i_FP_PWR_BTN_N;
  assign dur_last = long_q ? LONG_LAST : SHORT_LAST;

  always_comb begin
    state_d  = state_q;
    long_d   = long_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fp_fall && !i_FP_DISABLE) begin
          state_d  = FP_PRESS;
          reject_d = i_BMC_PWR_BTN;
        end else if (i_BMC_PWR_BTN) begin
          state_d = BMC_PRESS;
          long_d  = i_BMC_LONG;
        end
      end
      FP_PRESS: begin
        reject_d = i_BMC_PWR_BTN;
        // An early release is held low until the minimum width has elapsed.
        if (i_FP_PWR_BTN_N && (cnt_q >= FP_MIN_LAST)) state_d = GAP;
      end
      BMC_PRESS: begin
        reject_d = i_BMC_PWR_BTN;
        if (cnt_q == dur_last) begin
          state_d = GAP;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        reject_d = i_BMC_PWR_BTN;
        if (cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state entry and saturates otherwise.
  always_comb begin
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_comb begin
    pwrbtn_n_d = 1'b1;
    owner_d    = 2'b00;
    busy_d     = (state_d != IDLE);
    case (state_d)
      FP_PRESS: begin
        pwrbtn_n_d = 1'b0;
        owner_d    = 2'b01;
      end
      BMC_PRESS: begin
        pwrbtn_n_d = 1'b0;
        owner_d    = 2'b10;
      end
      default: begin
        pwrbtn_n_d = 1'b1;
        owner_d    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fp_prev_q  <= 1'b1;
      long_q     <= 1'b0;
      pwrbtn_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      owner_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fp_prev_q  <= i_FP_PWR_BTN_N;
      long_q     <= long_d;
      pwrbtn_n_q <= pwrbtn_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
      owner_q    <= owner_d;
    end
  end

  assign o_FM_PCH_PWRBTN_N = pwrbtn_n_q;
  assign o_BMC_BUSY        = busy_q;
  assign o_BMC_DONE        = done_q;
  assign o_BMC_REJECT      = reject_q;
  assign o_OWNER           = owner_q;

endmodule

// File: tb/tb_pwr_btn_arbiter.sv
// Directed bench for pwr_btn_arbiter: a countdown-based press model checked every cycle,
// plus per-scenario hand-computed totals of low cycles, pulses and ownership.
module tb_pwr_btn_arbiter;

  localparam int unsigned CNT_W = 8, SHORT_CYC = 4, LONG_CYC = 10, GAP_CYC = 3, FP_MIN_CYC = 5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       i_FP_PWR_BTN_N, i_FP_DISABLE, i_BMC_PWR_BTN, i_BMC_LONG;
  logic       o_FM_PCH_PWRBTN_N, o_BMC_BUSY, o_BMC_DONE, o_BMC_REJECT;
  logic [1:0] o_OWNER;

  int n_checks = 0;
  int n_fail   = 0;

  pwr_btn_arbiter #(
    .CNT_W(CNT_W), .SHORT_CYC(SHORT_CYC), .LONG_CYC(LONG_CYC),
    .GAP_CYC(GAP_CYC), .FP_MIN_CYC(FP_MIN_CYC)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .i_FP_PWR_BTN_N(i_FP_PWR_BTN_N), .i_FP_DISABLE(i_FP_DISABLE),
    .i_BMC_PWR_BTN(i_BMC_PWR_BTN), .i_BMC_LONG(i_BMC_LONG),
    .o_FM_PCH_PWRBTN_N(o_FM_PCH_PWRBTN_N), .o_BMC_BUSY(o_BMC_BUSY),
    .o_BMC_DONE(o_BMC_DONE), .o_BMC_REJECT(o_BMC_REJECT), .o_OWNER(o_OWNER)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who holds the line, and how many more cycles the current phase must last.
  typedef enum {M_IDLE, M_FP, M_BMC, M_GAP} mode_t;
  mode_t m_mode;
  int    m_rem;
  logic  m_fp_prev;
  logic  m_done, m_rej;

  // Observed totals, cleared by each scenario.
  int low_cnt, done_cnt, rej_cnt, busy_cnt, own_fp_cnt, own_bmc_cnt;

  task automatic clr_totals();
    low_cnt = 0; done_cnt = 0; rej_cnt = 0; busy_cnt = 0; own_fp_cnt = 0; own_bmc_cnt = 0;
  endtask

  always @(posedge CLK) begin
    m_done = 1'b0;
    m_rej  = 1'b0;
    if (RESET) begin
      m_mode    = M_IDLE;
      m_rem     = 0;
      m_fp_prev = 1'b1;
    end else begin
      if (m_mode != M_IDLE && i_BMC_PWR_BTN) m_rej = 1'b1;
      case (m_mode)
        M_IDLE: begin
          if (m_fp_prev && !i_FP_PWR_BTN_N && !i_FP_DISABLE) begin
            m_mode = M_FP; m_rem = FP_MIN_CYC - 1; m_rej = i_BMC_PWR_BTN;
          end else if (i_BMC_PWR_BTN) begin
            m_mode = M_BMC; m_rem = (i_BMC_LONG ? LONG_CYC : SHORT_CYC) - 1;
          end
        end
        M_FP: begin
          if (m_rem == 0 && i_FP_PWR_BTN_N) begin
            m_mode = M_GAP; m_rem = GAP_CYC - 1;
          end else if (m_rem > 0) m_rem--;
        end
        M_BMC: begin
          if (m_rem == 0) begin
            m_mode = M_GAP; m_rem = GAP_CYC - 1; m_done = 1'b1;
          end else m_rem--;
        end
        M_GAP: begin
          if (m_rem == 0) m_mode = M_IDLE;
          else m_rem--;
        end
      endcase
      m_fp_prev = i_FP_PWR_BTN_N;
    end
    #1;
    chk("pwrbtn_n", o_FM_PCH_PWRBTN_N, (m_mode == M_FP || m_mode == M_BMC) ? 1'b0 : 1'b1);
    chk("busy",     o_BMC_BUSY, (m_mode != M_IDLE) ? 1'b1 : 1'b0);
    chk("owner",    o_OWNER, (m_mode == M_FP) ? 2'b01 : (m_mode == M_BMC) ? 2'b10 : 2'b00);
    chk("done",     o_BMC_DONE, m_done);
    chk("reject",   o_BMC_REJECT, m_rej);
    if (o_FM_PCH_PWRBTN_N == 1'b0) low_cnt++;
    if (o_BMC_DONE)   done_cnt++;
    if (o_BMC_REJECT) rej_cnt++;
    if (o_BMC_BUSY)   busy_cnt++;
    if (o_OWNER == 2'b01) own_fp_cnt++;
    if (o_OWNER == 2'b10) own_bmc_cnt++;
  end

  // driver tasks (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bmc_strobe(input logic long_sel);
    i_BMC_PWR_BTN = 1'b1; i_BMC_LONG = long_sel;
    tick(1);
    i_BMC_PWR_BTN = 1'b0; i_BMC_LONG = 1'b0;
  endtask

  task automatic fp_press(input int cycles);
    i_FP_PWR_BTN_N = 1'b0;
    tick(cycles);
    i_FP_PWR_BTN_N = 1'b1;
  endtask

  initial begin
    RESET = 1'b1; i_FP_PWR_BTN_N = 1'b1; i_FP_DISABLE = 1'b0;
    i_BMC_PWR_BTN = 1'b0; i_BMC_LONG = 1'b0;
    tick(2);
    chk("rst_pwrbtn_n", o_FM_PCH_PWRBTN_N, 1'b1);
    chk("rst_busy", o_BMC_BUSY, 1'b0);
    chk("rst_owner", o_OWNER, 2'b00);
    chk("rst_done_rej", {o_BMC_DONE, o_BMC_REJECT}, 2'b00);
    RESET = 1'b0;
    tick(2);

    // 1: short BMC press
    clr_totals();
    bmc_strobe(1'b0);
    tick(12);
    chk("s1_low", low_cnt, 4);
    chk("s1_done", done_cnt, 1);
    chk("s1_busy", busy_cnt, 7);
    chk("s1_own_bmc", own_bmc_cnt, 4);
    chk("s1_rej", rej_cnt, 0);

    // 2: long BMC press with a second strobe two cycles later
    clr_totals();
    bmc_strobe(1'b1);
    tick(1);
    bmc_strobe(1'b0);
    tick(20);
    chk("s2_low", low_cnt, 10);
    chk("s2_rej", rej_cnt, 1);
    chk("s2_done", done_cnt, 1);
    chk("s2_busy", busy_cnt, 13);

    // 3: front panel held 20 cycles
    clr_totals();
    fp_press(20);
    tick(10);
    chk("s3_low", low_cnt, 20);
    chk("s3_own_fp", own_fp_cnt, 20);
    chk("s3_busy", busy_cnt, 23);
    chk("s3_done", done_cnt, 0);

    // 4: one-cycle tap stretched to the minimum, then a press under lockout
    clr_totals();
    fp_press(1);
    tick(12);
    chk("s4_low", low_cnt, 5);
    chk("s4_busy", busy_cnt, 8);
    clr_totals();
    i_FP_DISABLE = 1'b1;
    fp_press(3);
    tick(3);
    i_FP_DISABLE = 1'b0;
    tick(3);
    chk("s4_dis_low", low_cnt, 0);
    chk("s4_dis_busy", busy_cnt, 0);

    // 5: simultaneous front-panel edge and BMC strobe
    clr_totals();
    i_FP_PWR_BTN_N = 1'b0;
    bmc_strobe(1'b0);
    tick(2);
    i_FP_PWR_BTN_N = 1'b1;
    tick(12);
    chk("s5_low", low_cnt, 5);
    chk("s5_own_fp", own_fp_cnt, 5);
    chk("s5_rej", rej_cnt, 1);
    chk("s5_done", done_cnt, 0);
    // front panel pressed during BMC press and held past the gap
    clr_totals();
    bmc_strobe(1'b0);
    tick(1);
    fp_press(15);
    tick(5);
    chk("s5_held_low", low_cnt, 4);
    chk("s5_held_own_fp", own_fp_cnt, 0);
    chk("s5_held_done", done_cnt, 1);
    clr_totals();
    fp_press(1);
    tick(12);
    chk("s5_repress_low", low_cnt, 5);
    chk("s5_repress_own_fp", own_fp_cnt, 5);

    // 6: reset in the third cycle of a long BMC press
    clr_totals();
    bmc_strobe(1'b1);
    tick(1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("s6_pwrbtn_n", o_FM_PCH_PWRBTN_N, 1'b1);
    chk("s6_busy", o_BMC_BUSY, 1'b0);
    chk("s6_owner", o_OWNER, 2'b00);
    tick(12);
    chk("s6_low", low_cnt, 2);
    chk("s6_done", done_cnt, 0);
    clr_totals();
    bmc_strobe(1'b0);
    tick(12);
    chk("s6_after_low", low_cnt, 4);
    chk("s6_after_done", done_cnt, 1);
    chk("s6_after_rej", rej_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
